bcd_serial_add_ctrl: RTL

Multi-digit BCD addition controller that time-shares one single-digit BCD add stage across all digit positions. Operands are loaded on `start` and processed one digit per cycle, least significant first, with the decimal carry held in a register between digits. The block sits between a request source and any consumer of packed-BCD sums. It replaces a wide combinational ripple of BCD adders with a small sequenced datapath.

---
 rtl/bcd_serial_add_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Purpose  : Multi-digit packed-BCD adder. One single-digit BCD add stage is
//            reused for every digit position, least significant digit first.
//            The decimal carry is held in a register between digits.
//            Optional input-digit checking is built when BCD_CTRL_CHECK_EN is
//            defined. Without it, err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_ADD  = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_carry;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_sum;
    logic                r_cout;

    logic                w_load;
    logic                w_in_add;
    logic                w_last;
    logic [3:0]          w_ai;
    logic [3:0]          w_bi;
    logic [4:0]          w_s;
    logic                w_gt9;
    logic [3:0]          w_digit;
    logic [4*DIGITS-1:0] w_acc_next;

    // A request is accepted only when no addition is in flight.
    assign w_load   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_in_add = (r_state == c_ADD);
    assign w_last   = w_in_add && (r_cnt == c_LAST);

    // Single-digit BCD stage. Non-BCD digits follow the same +6 rule.
    assign w_ai    = r_a[3:0];
    assign w_bi    = r_b[3:0];
    assign w_s     = {1'b0, w_ai} + {1'b0, w_bi} + {4'b0000, r_carry};
    assign w_gt9   = (w_s > 5'd9);
    assign w_digit = w_gt9 ? (w_s[3:0] + 4'd6) : w_s[3:0];

    assign busy = w_in_add;
    assign done = (r_state == c_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: DONE lasts one cycle and can accept a new request
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_ADD;
            c_ADD:   if (r_cnt == c_LAST) w_next_state = c_DONE;
            c_DONE:  w_next_state = start ? c_ADD : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Operand shift, carry chain, digit counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_in_add) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_gt9;
            r_cnt   <= r_cnt + c_ONE;
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_gt9;
            end
        end
    end

    // The result shift register holds the DIGITS-1 digits already computed.
    // The current digit enters at the top, so after the last digit the
    // concatenation is the complete sum with digit 0 in bits [3:0].
    generate
        if (DIGITS > 1) begin : g_acc_multi
            logic [4*DIGITS-5:0] r_acc;

            assign w_acc_next = {w_digit, r_acc};

            // Shift each new result digit in from the top
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_load) begin
                    r_acc <= '0;
                end else if (w_in_add) begin
                    r_acc <= w_acc_next[4*DIGITS-1:4];
                end
            end
        end else begin : g_acc_single
            assign w_acc_next = w_digit;
        end
    endgenerate

`ifdef BCD_CTRL_CHECK_EN
    logic r_err_flag;
    logic r_err;
    logic w_bad;

    assign w_bad = (w_ai > 4'd9) || (w_bi > 4'd9);
    assign err   = r_err;

    // Sticky non-BCD detector. It is published together with the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_flag <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_load) begin
            r_err_flag <= 1'b0;
        end else if (w_in_add) begin
            r_err_flag <= r_err_flag | w_bad;
            if (w_last) begin
                r_err <= r_err_flag | w_bad;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
